// File: rtl/tri_scheduler.sv
// Per-frame triangle sequencer between the mesh ROM and the rasterizer.
// Reads four 96-bit ROM rows per triangle and presents each triangle on a valid/ready handshake.
module tri_scheduler #(
  parameter int NUM_TRIS     = 12,
  parameter int ROWS_PER_TRI = 4,
  parameter int ROM_LATENCY  = 2,
  parameter int ADDR_W       = $clog2(NUM_TRIS*4)
) (
  input  logic                                clk_in,
  input  logic                                rst_n_in,
  input  logic                                enable_in,
  input  logic                                new_frame_in,
  output logic [ADDR_W-1:0]                   rom_addr_out,
  input  logic [95:0]                         rom_data_in,
  output logic [3:0][2:0][31:0]               triangle_out,
  output logic                                tri_valid_out,
  input  logic                                tri_ready_in,
  output logic                                obj_done_out,
  output logic                                busy_out,
  output logic [$clog2(NUM_TRIS+1)-1:0]       tri_index_out,
  output logic                                overrun_out
);

  localparam int IDX_W    = $clog2(NUM_TRIS+1);
  localparam int LAST_ROW = ROWS_PER_TRI - 1;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WAIT,
    PRESENT
  } state_e;

  state_e                      state_q;
  logic [ADDR_W-1:0]           rom_addr_q;
  logic [1:0]                  row_q;
  logic [IDX_W-1:0]            idx_q;
  logic                        valid_q;
  logic                        done_q;
  logic                        overrun_q;
  logic [3:0][2:0][31:0]       tri_q;
  logic [ROM_LATENCY-1:0]      tag_vld_q;
  logic [ROM_LATENCY-1:0][1:0] tag_row_q;

  logic                        xfer;
  logic                        last_xfer;
  logic                        abort;
  logic                        restart;
  logic                        issue;
  logic                        cap_vld;
  logic                        cap_last;
  logic [1:0]                  cap_row;
  logic [ADDR_W-1:0]           next_base;

  // A new_frame landing on the final transfer completes the frame instead of aborting it.
  always_comb begin
    xfer      = valid_q & tri_ready_in;
    last_xfer = xfer & (idx_q == IDX_W'(NUM_TRIS - 1));
    abort     = new_frame_in & (state_q != IDLE) & ~last_xfer;
    restart   = abort | last_xfer | ((state_q == IDLE) & new_frame_in);
    issue     = (state_q == FETCH) & ~abort;
    cap_vld   = tag_vld_q[ROM_LATENCY-1] & ~abort;
    cap_row   = tag_row_q[ROM_LATENCY-1];
    cap_last  = cap_vld & (cap_row == 2'(LAST_ROW));
    next_base = ADDR_W'((32'(idx_q) + 32'd1) * 32'(ROWS_PER_TRI));
  end

  // Each issued address carries its row tag down a pipeline matched to the ROM latency.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      tag_vld_q <= '0;
      tag_row_q <= '0;
      tri_q     <= '0;
    end else begin
      if (cap_vld) begin
        tri_q[cap_row] <= rom_data_in;
      end
      for (int i = ROM_LATENCY - 1; i > 0; i--) begin
        tag_vld_q[i] <= tag_vld_q[i-1] & ~abort;
        tag_row_q[i] <= tag_row_q[i-1];
      end
      tag_vld_q[0] <= issue;
      tag_row_q[0] <= row_q;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= IDLE;
      rom_addr_q <= '0;
      row_q      <= '0;
      idx_q      <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      done_q <= last_xfer;
      if (abort) begin
        overrun_q <= 1'b1;
      end
      if (restart) begin
        valid_q <= 1'b0;
        if (new_frame_in && enable_in) begin
          state_q    <= FETCH;
          idx_q      <= '0;
          row_q      <= '0;
          rom_addr_q <= '0;
        end else begin
          state_q <= IDLE;
        end
      end else begin
        unique case (state_q)
          IDLE: begin
            state_q <= IDLE;
          end
          FETCH: begin
            if (row_q == 2'(LAST_ROW)) begin
              state_q <= WAIT;
            end else begin
              row_q      <= row_q + 2'd1;
              rom_addr_q <= rom_addr_q + 1'b1;
            end
          end
          WAIT: begin
            if (cap_last) begin
              state_q <= PRESENT;
              valid_q <= 1'b1;
            end
          end
          PRESENT: begin
            if (xfer) begin
              valid_q    <= 1'b0;
              idx_q      <= idx_q + 1'b1;
              row_q      <= '0;
              rom_addr_q <= next_base;
              state_q    <= FETCH;
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign rom_addr_out  = rom_addr_q;
  assign triangle_out  = tri_q;
  assign tri_valid_out = valid_q;
  assign obj_done_out  = done_q;
  assign busy_out      = (state_q != IDLE);
  assign tri_index_out = idx_q;
  assign overrun_out   = overrun_q;

endmodule
